// File: rtl/misc_pkg.sv
// Shared scalar typedefs used across the device-side blocks.
package misc_pkg;

  typedef logic [63:0] U64;
  typedef logic [31:0] U32;

endpackage

// File: rtl/msix_pkg.sv
// MSI-X vector table entry type, initiator FSM states and table limits.
package msix_pkg;

  import misc_pkg::*;

  localparam int MSIX_MAX_VEC = 64;

  typedef struct packed {
    U64   addr;
    U32   data;
    logic mask;
  } msix_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } msix_state_e;

  // Out of reset every vector is masked with a zero address/data.
  function automatic msix_entry_t msix_entry_reset();
    msix_entry_t e;
    e.addr = '0;
    e.data = '0;
    e.mask = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/msix_rr_arb.sv
// Combinational round-robin arbiter: searches upward from the slot after
// the last grant, wrapping at NUM_VEC.
module msix_rr_arb #(
  parameter int NUM_VEC = 8,
  parameter int VEC_W   = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
  input  logic [NUM_VEC-1:0] req,
  input  logic [VEC_W-1:0]   last_grant,
  input  logic               enable,
  output logic [VEC_W-1:0]   grant,
  output logic               grant_valid
);

  always_comb begin
    int               idx;
    logic [VEC_W-1:0] sel;
    idx         = 0;
    sel         = '0;
    grant       = '0;
    grant_valid = 1'b0;
    for (int off = 0; off < NUM_VEC; off++) begin
      idx = int'(last_grant) + 1 + off;
      if (idx >= NUM_VEC) begin
        idx = idx - NUM_VEC;
      end
      sel = VEC_W'(idx);
      if (enable && !grant_valid && req[sel]) begin
        grant_valid = 1'b1;
        grant       = sel;
      end
    end
  end

endmodule

// File: rtl/msix_intr_gen.sv
// MSI-X message initiator: vector table, pending-bit array and a
// round-robin scheduler feeding a valid/ready single-DW write port.
module msix_intr_gen
  import msix_pkg::*;
#(
  parameter int NUM_VEC = 8,
  parameter int VEC_W   = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               msix_en,
  input  logic               func_mask,
  input  logic               cfg_we,
  input  logic [VEC_W-1:0]   cfg_vec,
  input  logic [63:0]        cfg_addr,
  input  logic [31:0]        cfg_data,
  input  logic               cfg_mask,
  input  logic [NUM_VEC-1:0] intr_req,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [63:0]        wr_addr,
  output logic [31:0]        wr_data,
  output logic [VEC_W-1:0]   wr_vec,
  output logic [NUM_VEC-1:0] pending,
  output logic [31:0]        sent_cnt
);

  msix_entry_t        vec_table [NUM_VEC];
  msix_state_e        state_q;
  msix_state_e        state_d;
  logic [NUM_VEC-1:0] mask_vec;
  logic [NUM_VEC-1:0] eligible;
  logic [NUM_VEC-1:0] pend_clr;
  logic [VEC_W-1:0]   last_grant_q;
  logic [VEC_W-1:0]   grant;
  logic               grant_valid;
  logic               issue_en;
  logic               load;
  logic               handshake;

  always_comb begin
    mask_vec = '0;
    for (int i = 0; i < NUM_VEC; i++) begin
      mask_vec[i] = vec_table[i].mask;
    end
  end

  assign issue_en = msix_en & ~func_mask;
  assign eligible = pending & ~mask_vec & {NUM_VEC{issue_en}};

  msix_rr_arb #(
    .NUM_VEC (NUM_VEC),
    .VEC_W   (VEC_W)
  ) u_arb (
    .req         (eligible),
    .last_grant  (last_grant_q),
    .enable      (state_q == IDLE),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    handshake = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          load    = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (wr_ready) begin
          handshake = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_valid = (state_q == REQ);

  always_comb begin
    pend_clr = '0;
    if (handshake) begin
      for (int i = 0; i < NUM_VEC; i++) begin
        if (wr_vec == VEC_W'(i)) begin
          pend_clr[i] = 1'b1;
        end
      end
    end
  end

  // Out-of-range cfg_vec matches no entry and is therefore dropped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_VEC; i++) begin
      if (rst) begin
        vec_table[i] <= msix_entry_reset();
      end else if (cfg_we && (cfg_vec == VEC_W'(i))) begin
        vec_table[i].addr <= {cfg_addr[63:2], 2'b00};
        vec_table[i].data <= cfg_data;
        vec_table[i].mask <= cfg_mask;
      end
    end
  end

  // A request landing in the handshake cycle wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~pend_clr) | intr_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr      <= '0;
      wr_data      <= '0;
      wr_vec       <= '0;
      last_grant_q <= VEC_W'(NUM_VEC - 1);
    end else if (load) begin
      wr_addr      <= vec_table[grant].addr;
      wr_data      <= vec_table[grant].data;
      wr_vec       <= grant;
      last_grant_q <= grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sent_cnt <= '0;
    end else if (handshake) begin
      sent_cnt <= sent_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_msix_intr_gen.sv
// Self-checking bench for msix_intr_gen: directed scenarios plus a random
// phase, all compared every cycle against a message-level reference model.
module tb_msix_intr_gen;

  localparam int NUM_VEC = 8;
  localparam int VEC_W   = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               msix_en;
  logic               func_mask;
  logic               cfg_we;
  logic [VEC_W-1:0]   cfg_vec;
  logic [63:0]        cfg_addr;
  logic [31:0]        cfg_data;
  logic               cfg_mask;
  logic [NUM_VEC-1:0] intr_req;
  logic               wr_valid;
  logic               wr_ready;
  logic [63:0]        wr_addr;
  logic [31:0]        wr_data;
  logic [VEC_W-1:0]   wr_vec;
  logic [NUM_VEC-1:0] pending;
  logic [31:0]        sent_cnt;

  int n_vec = 0;
  int n_err = 0;
  int cycle = 0;

  logic [63:0] m_addr [NUM_VEC];
  logic [31:0] m_data [NUM_VEC];
  bit          m_mask [NUM_VEC];
  bit          m_pend [NUM_VEC];
  bit          m_busy;
  int          m_cur;
  logic [63:0] m_cur_addr;
  logic [31:0] m_cur_data;
  int          m_last;
  logic [31:0] m_cnt;
  int          msg_log [$];
  int          msg_cyc [$];
  int          rr_exp [3];

  msix_intr_gen #(
    .NUM_VEC (NUM_VEC),
    .VEC_W   (VEC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .msix_en   (msix_en),
    .func_mask (func_mask),
    .cfg_we    (cfg_we),
    .cfg_vec   (cfg_vec),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_mask  (cfg_mask),
    .intr_req  (intr_req),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_vec    (wr_vec),
    .pending   (pending),
    .sent_cnt  (sent_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Message-level model: one outstanding write, pick the next eligible
  // vector after the last one sent, requests set pending after clears.
  task automatic modelStep();
    int pick;
    int v;
    pick = -1;
    if (rst) begin
      for (int i = 0; i < NUM_VEC; i++) begin
        m_addr[i] = '0;
        m_data[i] = '0;
        m_mask[i] = 1'b1;
        m_pend[i] = 1'b0;
      end
      m_busy     = 1'b0;
      m_cur      = 0;
      m_cur_addr = '0;
      m_cur_data = '0;
      m_last     = NUM_VEC - 1;
      m_cnt      = '0;
    end else begin
      if (m_busy) begin
        if (wr_ready) begin
          m_pend[m_cur] = 1'b0;
          m_cnt         = m_cnt + 32'd1;
          m_busy        = 1'b0;
          msg_log.push_back(m_cur);
          msg_cyc.push_back(cycle);
        end
      end else if (msix_en && !func_mask) begin
        for (int k = 1; k <= NUM_VEC; k++) begin
          v = (m_last + k) % NUM_VEC;
          if (pick < 0 && m_pend[v] && !m_mask[v]) pick = v;
        end
        if (pick >= 0) begin
          m_busy     = 1'b1;
          m_cur      = pick;
          m_cur_addr = m_addr[pick];
          m_cur_data = m_data[pick];
          m_last     = pick;
        end
      end
      for (int i = 0; i < NUM_VEC; i++) begin
        if (intr_req[i]) m_pend[i] = 1'b1;
      end
      if (cfg_we && int'(cfg_vec) < NUM_VEC) begin
        m_addr[cfg_vec] = {cfg_addr[63:2], 2'b00};
        m_data[cfg_vec] = cfg_data;
        m_mask[cfg_vec] = cfg_mask;
      end
    end
  endtask

  task automatic checkOutput();
    logic [NUM_VEC-1:0] exp_pend;
    exp_pend = '0;
    for (int i = 0; i < NUM_VEC; i++) exp_pend[i] = m_pend[i];
    checkValue("wr_valid", wr_valid, m_busy);
    checkValue("pending", pending, exp_pend);
    checkValue("sent_cnt", sent_cnt, m_cnt);
    if (m_busy) begin
      checkValue("wr_addr", wr_addr, m_cur_addr);
      checkValue("wr_data", wr_data, m_cur_data);
      checkValue("wr_vec", wr_vec, m_cur);
    end
  endtask

  task automatic applyStimulus(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      modelStep();
      cycle++;
      #1;
      checkOutput();
      intr_req = '0;
      cfg_we   = 1'b0;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(2);
    rst = 1'b0;
  endtask

  task automatic cfgWrite(input int vec, input logic [63:0] addr, input logic [31:0] data, input logic mask);
    cfg_we   = 1'b1;
    cfg_vec  = VEC_W'(vec);
    cfg_addr = addr;
    cfg_data = data;
    cfg_mask = mask;
    applyStimulus(1);
  endtask

  initial begin
    rst = 1'b1; msix_en = 1'b0; func_mask = 1'b0; cfg_we = 1'b0;
    cfg_vec = '0; cfg_addr = '0; cfg_data = '0; cfg_mask = 1'b0;
    intr_req = '0; wr_ready = 1'b1;
    rr_exp[0] = 0; rr_exp[1] = 3; rr_exp[2] = 5;

    applyStimulus(2);
    checkValue("reset_wr_addr", wr_addr, 64'h0);
    checkValue("reset_wr_data", wr_data, 64'h0);
    checkValue("reset_wr_vec", wr_vec, 64'h0);
    rst = 1'b0;

    // Every vector comes out of reset masked.
    msix_en  = 1'b1;
    intr_req = '1;
    applyStimulus(6);
    checkValue("reset_mask_pend", pending, 64'hff);
    checkValue("reset_mask_nomsg", msg_log.size(), 64'd0);

    // Basic send with the two-cycle request-to-valid latency.
    doReset();
    cfgWrite(2, 64'h0000_0001_0000_1008, 32'hDEAD_0002, 1'b0);
    msg_log.delete();
    intr_req = 8'b0000_0100;
    applyStimulus(1);
    checkValue("basic_n1_valid", wr_valid, 64'd0);
    checkValue("basic_n1_pend", pending[2], 64'd1);
    applyStimulus(1);
    checkValue("basic_n2_valid", wr_valid, 64'd1);
    checkValue("basic_addr", wr_addr, 64'h0000_0001_0000_1008);
    checkValue("basic_data", wr_data, 64'hDEAD_0002);
    checkValue("basic_vec", wr_vec, 64'd2);
    applyStimulus(1);
    checkValue("basic_pend_clr", pending[2], 64'd0);
    checkValue("basic_cnt", sent_cnt, 64'd1);

    // Round-robin order and spacing.
    doReset();
    cfgWrite(0, 64'h0000_0000_0000_1000, 32'hA000_0000, 1'b0);
    cfgWrite(3, 64'h0000_0000_0000_1033, 32'hA000_0003, 1'b0);
    cfgWrite(5, 64'h0000_0000_0000_1050, 32'hA000_0005, 1'b0);
    msg_log.delete();
    msg_cyc.delete();
    intr_req = 8'b0010_1001;
    applyStimulus(10);
    checkValue("rr_count", msg_log.size(), 64'd3);
    if (msg_log.size() == 3) begin
      for (int j = 0; j < 3; j++) checkValue("rr_order", msg_log[j], rr_exp[j]);
      checkValue("rr_gap01", msg_cyc[1] - msg_cyc[0], 64'd2);
      checkValue("rr_gap12", msg_cyc[2] - msg_cyc[1], 64'd2);
    end
    checkValue("rr_cnt", sent_cnt, 64'd3);

    // Masked vector holds its pending bit; unmasking sends exactly once.
    doReset();
    cfgWrite(1, 64'h0000_0000_0000_2000, 32'hB000_0001, 1'b1);
    msg_log.delete();
    for (int r = 0; r < 3; r++) begin
      intr_req = 8'b0000_0010;
      applyStimulus(2);
    end
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1);
      checkValue("mask_hold_valid", wr_valid, 64'd0);
      checkValue("mask_hold_pend", pending[1], 64'd1);
    end
    cfgWrite(1, 64'h0000_0000_0000_2000, 32'hB000_0001, 1'b0);
    applyStimulus(8);
    checkValue("unmask_count", msg_log.size(), 64'd1);
    checkValue("unmask_pend", pending[1], 64'd0);

    // Backpressure: request stays stable while its entry is rewritten.
    doReset();
    cfgWrite(4, 64'h0000_00AB_CDEF_0010, 32'h4444_0004, 1'b0);
    msg_log.delete();
    wr_ready = 1'b0;
    intr_req = 8'b0001_0000;
    applyStimulus(2);
    checkValue("bp_start_valid", wr_valid, 64'd1);
    for (int c = 0; c < 10; c++) begin
      if (c == 0) begin
        cfg_we = 1'b1; cfg_vec = 3'd4; cfg_addr = 64'h5555_0000;
        cfg_data = 32'h0000_1111; cfg_mask = 1'b1;
      end
      applyStimulus(1);
      checkValue("bp_valid", wr_valid, 64'd1);
      checkValue("bp_addr", wr_addr, 64'h0000_00AB_CDEF_0010);
      checkValue("bp_data", wr_data, 64'h4444_0004);
    end
    wr_ready = 1'b1;
    applyStimulus(1);
    checkValue("bp_sent", msg_log.size(), 64'd1);
    applyStimulus(10);
    checkValue("bp_no_more", msg_log.size(), 64'd1);
    checkValue("bp_idle", wr_valid, 64'd0);

    // Coalescing plus a request landing in the handshake cycle.
    doReset();
    cfgWrite(6, 64'h0000_0000_0000_6000, 32'h0000_0066, 1'b0);
    msg_log.delete();
    wr_ready = 1'b0;
    intr_req = 8'b0100_0000;
    applyStimulus(1);
    intr_req = 8'b0100_0000;
    applyStimulus(1);
    checkValue("coal_valid", wr_valid, 64'd1);
    applyStimulus(2);
    wr_ready = 1'b1;
    intr_req = 8'b0100_0000;
    applyStimulus(1);
    checkValue("coal_set_on_clr", pending[6], 64'd1);
    applyStimulus(8);
    checkValue("coal_count", msg_log.size(), 64'd2);

    // Reset while a request is outstanding.
    wr_ready = 1'b0;
    intr_req = 8'b0100_0000;
    applyStimulus(3);
    checkValue("rstreq_valid_before", wr_valid, 64'd1);
    rst = 1'b1;
    applyStimulus(1);
    checkValue("rstreq_valid", wr_valid, 64'd0);
    checkValue("rstreq_pend", pending, 64'd0);
    checkValue("rstreq_cnt", sent_cnt, 64'd0);
    rst = 1'b0;
    intr_req = '1;
    applyStimulus(6);
    checkValue("rstreq_masked_pend", pending, 64'hff);
    checkValue("rstreq_masked_valid", wr_valid, 64'd0);

    // Random traffic against the model.
    doReset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom % 6 == 0) begin
        cfg_we   = 1'b1;
        cfg_vec  = VEC_W'($urandom_range(0, NUM_VEC - 1));
        cfg_addr = {$urandom, $urandom};
        cfg_data = $urandom;
        cfg_mask = ($urandom % 3 == 0);
      end
      intr_req  = NUM_VEC'($urandom & $urandom & $urandom);
      wr_ready  = ($urandom % 4 != 0);
      msix_en   = ($urandom % 10 != 0);
      func_mask = ($urandom % 16 == 0);
      applyStimulus(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/msix_intr_gen.md
Name: msix_intr_gen

Overview:
- Device-side MSI-X message initiator: turns per-vector interrupt requests into single-DW posted memory writes toward host memory.
- Its write stream is what the host interface model consumes; a write hitting a registered MSI-X address is flagged there as an interrupt.
- Holds the vector table (address, data, mask), pending bits, a round-robin arbiter and a valid/ready write-request port.

Parameters:
- NUM_VEC, 8: number of MSI-X vectors (1..64).
- VEC_W, $clog2(NUM_VEC) (min 1): vector index width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- msix_en  input  1  global MSI-X enable; 0 = hold all pending, issue nothing new
- func_mask  input  1  function mask; same effect as msix_en=0
- cfg_we  input  1  table write strobe
- cfg_vec  input  VEC_W  table entry index
- cfg_addr  input  64  message address; bits[1:0] ignored, stored as 0
- cfg_data  input  32  message data
- cfg_mask  input  1  per-vector mask
- intr_req  input  NUM_VEC  one-cycle interrupt request per vector
- wr_valid  output  1  write request valid
- wr_ready  input  1  host side accepts write
- wr_addr  output  64  DW-aligned write address
- wr_data  output  32  write data
- wr_vec  output  VEC_W  vector being sent (debug/scoreboard)
- pending  output  NUM_VEC  pending-bit array (PBA)
- sent_cnt  output  32  total messages accepted, wraps at 2^32

Behaviour:
- Reset: wr_valid=0, wr_addr=0, wr_data=0, wr_vec=0, pending=0, sent_cnt=0, table addr/data=0, all masks=1, FSM=IDLE.
- Table write: on cfg_we, entry cfg_vec is updated at the next edge. cfg_vec>=NUM_VEC is ignored.
- Pending: intr_req[i]=1 sets pending[i] at the next edge. A repeat request while already pending coalesces (one message).
- Eligibility: eligible[i] = pending[i] & ~mask[i] & msix_en & ~func_mask.
- FSM IDLE:
  - If any vector is eligible, the arbiter picks a winner: round-robin, starting from the index after the last granted vector (initially 0).
  - The winner's addr/data are latched into wr_addr/wr_data/wr_vec, wr_valid goes to 1, FSM -> REQ.
- FSM REQ:
  - wr_valid, wr_addr, wr_data and wr_vec stay stable until wr_valid & wr_ready.
  - On handshake: pending[wr_vec] clears, sent_cnt increments, wr_valid drops, FSM -> IDLE.
  - At least one idle cycle between messages; peak rate is 1 message per 2 cycles.
- Latency: intr_req at cycle N gives pending at N+1 and wr_valid at N+2 when eligible and idle.
- Simultaneous set and clear: an intr_req for vector i in the handshake cycle of vector i leaves pending[i]=1, so a second message follows.
- Changes during REQ:
  - Masking, clearing msix_en, or rewriting the entry of the in-flight vector does not retract or alter the request; the latched values are sent.
  - A newly masked vector keeps its pending bit. Unmasking it later sends exactly one message.
- Reset mid-REQ: wr_valid=0 at the next edge and all state returns to reset values.

Decomposition:
- msix_pkg:
  - msix_entry_t struct {U64 addr; U32 data; bit mask}.
  - FSM enum msix_state_e {IDLE, REQ}.
  - MSIX_MAX_VEC=64.
  - Reuses U64/U32 from misc_pkg.
- Sub-module msix_rr_arb: parameterised NUM_VEC round-robin arbiter. Inputs: request vector, last-grant index, enable. Outputs: grant index and grant_valid. Combinational.

Test Plan:
- Basic send:
  - Stimulus: program vec 2 = addr 0x0000_0001_0000_1008, data 0xDEAD_0002, mask 0; msix_en=1, func_mask=0, wr_ready=1; pulse intr_req[2] at cycle N.
  - Required: wr_valid at N+2 with wr_addr=0x1_0000_1008, wr_data=0xDEAD_0002, wr_vec=2; pending[2]=0 afterwards; sent_cnt=1.
- Round-robin:
  - Stimulus: vectors 0, 3, 5 unmasked; intr_req=8'b0010_1001 in a single cycle; wr_ready=1.
  - Required: messages in order vec 0, 3, 5, spaced 2 cycles apart; sent_cnt=3.
- Mask hold:
  - Stimulus: vec 1 masked; pulse intr_req[1] three times; wait 20 cycles.
  - Required: no wr_valid and pending[1]=1 throughout. After cfg_mask=0 on vec 1: exactly one message.
- Backpressure and stability:
  - Stimulus: wr_ready=0 for 10 cycles after wr_valid, while vec 4 is rewritten to data 0x1111 and masked.
  - Required: wr_valid/addr/data stay unchanged for all 10 cycles, the original data is sent, then no further messages.
- Coalesce and set-on-clear:
  - Stimulus: intr_req[6] twice while pending; then once more in the handshake cycle of vec 6.
  - Required: exactly 2 messages from vec 6 in total.
- Reset mid-REQ:
  - Stimulus: assert rst while wr_valid=1 and wr_ready=0.
  - Required: next cycle wr_valid=0, pending=0, sent_cnt=0, all masks=1.
